// File: rtl/tff_cell.sv
// T flip-flop bit cell: toggles its state when t_i is high, synchronous active-high reset.
module tff_cell (
    input  logic clk,
    input  logic reset,
    input  logic t_i,
    output logic q_o
);

    logic q_q;
    logic q_d;

    assign q_d = q_q ^ t_i;

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/tff_updown_counter.sv
// Up/down modulo counter with load, optional saturation and a sticky overflow flag.
// Every count bit is held in a T flip-flop; its toggle is the difference between the next and current count.
module tff_updown_counter #(
    parameter int unsigned     WIDTH    = 8,
    parameter longint unsigned MODULUS  = 64'd1 << WIDTH,
    parameter bit              SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    localparam logic             DIR_UP   = 1'b1;
    localparam logic             DIR_DOWN = 1'b0;
    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 64'd1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] toggle;
    logic             at_max;
    logic             at_min;
    logic             set_evt;
    logic             ovf_q;
    logic             ovf_d;

    assign at_max = (count_q == MAX_VAL);
    assign at_min = (count_q == '0);

    // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
    always_comb begin
        count_d = count_q;
        set_evt = 1'b0;
        if (load) begin
            count_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
        end else if (en) begin
            if (up == DIR_UP) begin
                if (at_max) begin
                    set_evt = 1'b1;
                    count_d = SATURATE ? MAX_VAL : '0;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (at_min) begin
                    set_evt = 1'b1;
                    count_d = SATURATE ? '0 : MAX_VAL;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
    end

    assign toggle = count_d ^ count_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        tff_cell u_cell (
            .clk   (clk),
            .reset (reset),
            .t_i   (toggle[i]),
            .q_o   (count_q[i])
        );
    end

    // A new wrap/saturate event wins over a simultaneous clear.
    assign ovf_d = set_evt | (ovf_q & ~clr_ovf);

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign count = count_q;
    assign ovf   = ovf_q;
    assign tc    = en & (((up == DIR_UP) & at_max) | ((up == DIR_DOWN) & at_min));

endmodule

// File: tb/tb_tff_updown_counter.sv
// Bench for tff_updown_counter: three configurations share one stimulus stream and are
// compared each cycle against an integer reference model.
module tb_tff_updown_counter;

    localparam int NDUT = 3;

    logic       clk = 1'b0;
    logic       reset, en, up, load, clr_ovf;
    logic [3:0] load_val;

    logic [3:0] count_o [NDUT];
    logic       tc_o    [NDUT];
    logic       ovf_o   [NDUT];

    // Model state per configuration: 0 = mod-10 wrap, 1 = mod-10 saturate, 2 = mod-16 wrap.
    int mod_m [NDUT] = '{10, 10, 16};
    int sat_m [NDUT] = '{0, 1, 0};
    int cnt_m [NDUT];
    int ovf_m [NDUT];

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    tff_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
        .clr_ovf(clr_ovf), .count(count_o[0]), .tc(tc_o[0]), .ovf(ovf_o[0]));

    tff_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
        .clr_ovf(clr_ovf), .count(count_o[1]), .tc(tc_o[1]), .ovf(ovf_o[1]));

    tff_updown_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) dut_full (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
        .clr_ovf(clr_ovf), .count(count_o[2]), .tc(tc_o[2]), .ovf(ovf_o[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Apply one cycle of inputs: check tc combinationally, clock, then check count/ovf.
    task automatic step(input logic r, input logic e, input logic u, input logic l,
                        input logic [3:0] lv, input logic c);
        int n;
        bit ev;
        reset = r; en = e; up = u; load = l; load_val = lv; clr_ovf = c;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("tc[%0d]", k), 32'(tc_o[k]),
                  32'(e && ((u && cnt_m[k] == mod_m[k] - 1) || (!u && cnt_m[k] == 0))));
        end
        @(posedge clk);
        for (int k = 0; k < NDUT; k++) begin
            if (r) begin
                cnt_m[k] = 0;
                ovf_m[k] = 0;
            end else begin
                ev = 1'b0;
                if (l) begin
                    cnt_m[k] = (int'(lv) >= mod_m[k]) ? mod_m[k] - 1 : int'(lv);
                end else if (e) begin
                    n = cnt_m[k] + (u ? 1 : -1);
                    if (n < 0 || n >= mod_m[k]) begin
                        ev = 1'b1;
                        if (sat_m[k] != 0) n = (n < 0) ? 0 : mod_m[k] - 1;
                        else               n = (n < 0) ? mod_m[k] - 1 : 0;
                    end
                    cnt_m[k] = n;
                end
                ovf_m[k] = ev ? 1 : (c ? 0 : ovf_m[k]);
            end
        end
        #1;
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("count[%0d]", k), 32'(count_o[k]), 32'(cnt_m[k]));
            check($sformatf("ovf[%0d]", k), 32'(ovf_o[k]), 32'(ovf_m[k]));
        end
    endtask

    initial begin
        for (int k = 0; k < NDUT; k++) begin
            cnt_m[k] = 0;
            ovf_m[k] = 0;
        end

        // Reset state.
        step(1, 0, 0, 0, 4'd0, 0);
        step(1, 1, 1, 1, 4'd7, 1);
        check("reset_count", 32'(count_o[0]), 32'd0);

        // Count up 0..9 then wrap to 0.
        for (int i = 0; i < 10; i++) step(0, 1, 1, 0, 4'd0, 0);
        check("wrap_pre_count", 32'(count_o[0]), 32'd0);
        check("wrap_ovf", 32'(ovf_o[0]), 32'd1);
        check("sat_hold_count", 32'(count_o[1]), 32'd9);

        // Clear, load 3, count down through 0 to 9.
        step(0, 0, 0, 1, 4'd3, 1);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 4'd0, 0);
        check("down_wrap_count", 32'(count_o[0]), 32'd8);
        check("down_wrap_ovf", 32'(ovf_o[0]), 32'd1);

        // Saturating config holds at 9; clr_ovf alone clears.
        step(0, 0, 0, 1, 4'd9, 1);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 4'd0, 0);
        check("sat_top_count", 32'(count_o[1]), 32'd9);
        check("sat_top_ovf", 32'(ovf_o[1]), 32'd1);
        step(0, 0, 1, 0, 4'd0, 1);
        check("sat_clr_ovf", 32'(ovf_o[1]), 32'd0);

        // Load above range clamps; load beats en.
        step(0, 0, 0, 1, 4'd14, 0);
        check("clamp_count", 32'(count_o[0]), 32'd9);
        check("full_no_clamp", 32'(count_o[2]), 32'd14);
        step(0, 1, 1, 1, 4'd5, 0);
        check("load_wins", 32'(count_o[0]), 32'd5);

        // Reset mid-count overrides load, then counting restarts from 0.
        step(1, 0, 0, 0, 4'd0, 0);
        for (int i = 0; i < 6; i++) step(0, 1, 1, 0, 4'd0, 0);
        step(1, 1, 1, 1, 4'd7, 0);
        check("mid_reset_count", 32'(count_o[0]), 32'd0);
        step(0, 1, 1, 0, 4'd0, 0);
        check("after_reset_step", 32'(count_o[0]), 32'd1);

        // clr_ovf on the same edge as a wrap keeps ovf set.
        step(0, 0, 0, 1, 4'd9, 1);
        step(0, 1, 1, 0, 4'd0, 1);
        check("clr_vs_wrap", 32'(ovf_o[0]), 32'd1);

        // Direction flips every cycle, no dead cycle.
        step(0, 0, 0, 1, 4'd4, 1);
        for (int i = 0; i < 6; i++) step(0, 1, 1'(i % 2), 0, 4'd0, 0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0),
                 4'($urandom), 1'($urandom_range(0, 7) == 0));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
